// File: rtl/control_pipeline_if.sv
// Decode-stage control bundle between the decoder/register file and the
// control pipeline, plus the hazard and stage-register outputs it returns.
interface control_pipeline_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 3
);
  logic                  RegWriteD;
  logic [1:0]            ResultSrcD;
  logic                  MemWriteD;
  logic                  JumpD;
  logic                  BranchD;
  logic [ALUCTRL_W-1:0]  ALUControlD;
  logic                  ALUSrcD;
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] RdD;
  logic                  ZeroE;

  logic [ALUCTRL_W-1:0]  ALUControlE;
  logic                  ALUSrcE;
  logic                  PCSrcE;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  MemWriteM;
  logic                  RegWriteW;
  logic [1:0]            ResultSrcW;
  logic [REG_ADDR_W-1:0] RdW;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, Rs1D, Rs2D, RdD, ZeroE,
    input  ALUControlE, ALUSrcE, PCSrcE, ForwardAE, ForwardBE, MemWriteM,
           RegWriteW, ResultSrcW, RdW, StallF, StallD, FlushD, FlushE
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, Rs1D, Rs2D, RdD, ZeroE,
    output ALUControlE, ALUSrcE, PCSrcE, ForwardAE, ForwardBE, MemWriteM,
           RegWriteW, ResultSrcW, RdW, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/control_pipeline.sv
// Control side of the 5-stage core: carries decoded control through E/M/W and
// resolves load-use stalls, branch/jump flushes and E-stage forwarding.
module control_pipeline #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 3,
  parameter int FORWARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  control_pipeline_if.slave ctrl
);

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [ALUCTRL_W-1:0]  alu_ctrl;
    logic                  alu_src;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } e_stage_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd;
  } m_stage_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } w_stage_t;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

  e_stage_t e_q, e_d;
  m_stage_t m_q;
  w_stage_t w_q;

  logic       lw_stall;
  logic       pcsrc_e;
  logic       flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // x0 is never a forwarding source; M (younger) wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs_e,
    input logic                  rw_m,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  rw_w,
    input logic [REG_ADDR_W-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if ((rs_e != REG_X0) && rw_m && (rd_m == rs_e)) begin
      sel = 2'b10;
    end else if ((rs_e != REG_X0) && rw_w && (rd_w == rs_e)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection, redirect and forwarding selects.
  always_comb begin
    lw_stall = (e_q.result_src == 2'b01) && (e_q.rd != REG_X0) &&
               ((e_q.rd == ctrl.Rs1D) || (e_q.rd == ctrl.Rs2D));
    pcsrc_e  = (e_q.branch & ctrl.ZeroE) | e_q.jump;
    flush_e  = lw_stall | pcsrc_e;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    if (FORWARD_EN != 0) begin
      fwd_a = fwd_sel(e_q.rs1, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
      fwd_b = fwd_sel(e_q.rs2, m_q.reg_write, m_q.rd, w_q.reg_write, w_q.rd);
    end else begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

  // E-stage next value: the D-stage word, or an all-zero bubble on flush.
  always_comb begin
    e_d = {$bits(e_stage_t){1'b0}};
    if (flush_e) begin
      e_d = {$bits(e_stage_t){1'b0}};
    end else begin
      e_d.reg_write  = ctrl.RegWriteD;
      e_d.result_src = ctrl.ResultSrcD;
      e_d.mem_write  = ctrl.MemWriteD;
      e_d.jump       = ctrl.JumpD;
      e_d.branch     = ctrl.BranchD;
      e_d.alu_ctrl   = ctrl.ALUControlD;
      e_d.alu_src    = ctrl.ALUSrcD;
      e_d.rs1        = ctrl.Rs1D;
      e_d.rs2        = ctrl.Rs2D;
      e_d.rd         = ctrl.RdD;
    end
  end

  // E/M/W stage registers; never stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= {$bits(e_stage_t){1'b0}};
      m_q <= {$bits(m_stage_t){1'b0}};
      w_q <= {$bits(w_stage_t){1'b0}};
    end else begin
      e_q            <= e_d;
      m_q.reg_write  <= e_q.reg_write;
      m_q.result_src <= e_q.result_src;
      m_q.mem_write  <= e_q.mem_write;
      m_q.rd         <= e_q.rd;
      w_q.reg_write  <= m_q.reg_write;
      w_q.result_src <= m_q.result_src;
      w_q.rd         <= m_q.rd;
    end
  end

  assign ctrl.ALUControlE = e_q.alu_ctrl;
  assign ctrl.ALUSrcE     = e_q.alu_src;
  assign ctrl.PCSrcE      = pcsrc_e;
  assign ctrl.ForwardAE   = fwd_a;
  assign ctrl.ForwardBE   = fwd_b;
  assign ctrl.MemWriteM   = m_q.mem_write;
  assign ctrl.RegWriteW   = w_q.reg_write;
  assign ctrl.ResultSrcW  = w_q.result_src;
  assign ctrl.RdW         = w_q.rd;
  assign ctrl.StallF      = lw_stall;
  assign ctrl.StallD      = lw_stall;
  assign ctrl.FlushD      = pcsrc_e;
  assign ctrl.FlushE      = flush_e;

endmodule
